// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI responder: register map,
// status bit positions and the host strobe decode states.
package hpi_pkg;

    localparam logic [1:0] HPI_REG_DATA   = 2'd0;
    localparam logic [1:0] HPI_REG_MBX    = 2'd1;
    localparam logic [1:0] HPI_REG_ADDR   = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS = 2'd3;

    localparam int STS_MBX_OUT = 0;
    localparam int STS_MBX_IN  = 8;
    localparam int STS_OVF     = 15;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        ILLEGAL
    } strb_e;

endpackage

// File: rtl/hpi_if.sv
// Host-port bus between the HPI initiator (master) and the
// responder (slave); names match the initiator's PIO ports.
interface hpi_if;

    logic        hpi_cs_n;
    logic [1:0]  hpi_addr;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic [15:0] hpi_data_in;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic        hpi_int;

    modport master (
        output hpi_cs_n,
        output hpi_addr,
        output hpi_r_n,
        output hpi_w_n,
        output hpi_data_in,
        input  hpi_data_out,
        input  hpi_data_oe,
        input  hpi_int
    );

    modport slave (
        input  hpi_cs_n,
        input  hpi_addr,
        input  hpi_r_n,
        input  hpi_w_n,
        input  hpi_data_in,
        output hpi_data_out,
        output hpi_data_oe,
        output hpi_int
    );

endinterface

// File: rtl/hpi_resp_ram.sv
// Simple dual-port word RAM: host read/write port plus a
// read-only local port (read-before-write on collisions).
module hpi_resp_ram #(
    parameter int WORDS = 256,
    parameter int WAW   = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             h_we,
    input  logic             h_re,
    input  logic [WAW-1:0]   h_addr,
    input  logic [15:0]      h_wdata,
    output logic [15:0]      h_rdata,
    input  logic [WAW-1:0]   l_addr,
    output logic [15:0]      l_rdata
);

    logic [15:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (h_we) mem[h_addr] <= h_wdata;
        if (h_re) h_rdata <= mem[h_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) l_rdata <= '0;
        else        l_rdata <= mem[l_addr];
    end

endmodule

// File: rtl/hpi_responder.sv
// Device end of the 4-register HPI: word memory with auto-increment
// pointer, bidirectional mailbox and status register.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS) + 1
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    hpi_if.slave          hpi,
    input  logic          dev_mbx_out_wr,
    input  logic [15:0]   dev_mbx_out_data,
    output logic          dev_mbx_in_valid,
    output logic [15:0]   dev_mbx_in_data,
    input  logic          dev_mbx_in_ack,
    input  logic [AW-2:0] dev_mem_addr,
    output logic [15:0]   dev_mem_rdata
);

    strb_e          cur_s, prv_s;
    logic [1:0]     sel_q;
    logic [15:0]    reg_q, reg_src, sts, ram_q, mbx_out;
    logic [AW-1:0]  ptr, ptr_nx;
    logic           out_full, in_full, ovf;
    logic           rd, wr_rise, rd_fall;
    logic           ram_we, ram_re, mbx_wr;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) prv_s <= IDLE;
        else                prv_s <= cur_s;
    end

    always_comb begin
        cur_s = IDLE;
        unique case (1'b1)
            hpi.hpi_cs_n | (hpi.hpi_r_n & hpi.hpi_w_n):
                cur_s = IDLE;
            !hpi.hpi_cs_n & !hpi.hpi_r_n & hpi.hpi_w_n:
                cur_s = RD;
            !hpi.hpi_cs_n & hpi.hpi_r_n & !hpi.hpi_w_n:
                cur_s = WR;
            !hpi.hpi_cs_n & !hpi.hpi_r_n & !hpi.hpi_w_n:
                cur_s = ILLEGAL;
            default:
                cur_s = IDLE;
        endcase
    end

    assign rd      = (cur_s == RD);
    assign wr_rise = (cur_s == WR) && (prv_s != WR);
    assign rd_fall = (prv_s == RD) && (cur_s != RD);
    assign ram_we  = wr_rise && (hpi.hpi_addr == HPI_REG_DATA);
    assign ram_re  = rd && (hpi.hpi_addr == HPI_REG_DATA);
    assign mbx_wr  = wr_rise && (hpi.hpi_addr == HPI_REG_MBX);

    always_comb begin
        sts              = '0;
        sts[STS_OVF]     = ovf;
        sts[STS_MBX_IN]  = in_full;
        sts[STS_MBX_OUT] = out_full;
    end

    always_comb begin
        reg_src = '0;
        unique case (hpi.hpi_addr)
            HPI_REG_MBX:    reg_src = mbx_out;
            HPI_REG_ADDR:   reg_src = 16'(ptr);
            HPI_REG_STATUS: reg_src = sts;
            default:        reg_src = '0;
        endcase
    end

    // Read release and a new write can land in the same cycle.
    always_comb begin
        ptr_nx = ptr;
        if (rd_fall && sel_q == HPI_REG_DATA)
            ptr_nx = ptr_nx + AW'(2);
        if (ram_we)
            ptr_nx = ptr_nx + AW'(2);
        if (wr_rise && hpi.hpi_addr == HPI_REG_ADDR)
            ptr_nx = {hpi.hpi_data_in[AW-1:1], 1'b0};
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sel_q           <= HPI_REG_STATUS;
            reg_q           <= '0;
            ptr             <= '0;
            mbx_out         <= '0;
            out_full        <= 1'b0;
            dev_mbx_in_data <= '0;
            in_full         <= 1'b0;
            ovf             <= 1'b0;
        end else begin
            ptr <= ptr_nx;
            if (rd) begin
                sel_q <= hpi.hpi_addr;
                reg_q <= reg_src;
            end
            if (rd_fall && sel_q == HPI_REG_MBX) out_full <= 1'b0;
            if (dev_mbx_out_wr) begin
                mbx_out  <= dev_mbx_out_data;
                out_full <= 1'b1;
            end
            if (rd_fall && sel_q == HPI_REG_STATUS) ovf <= 1'b0;
            if (dev_mbx_in_ack) in_full <= 1'b0;
            if (mbx_wr) begin
                dev_mbx_in_data <= hpi.hpi_data_in;
                in_full         <= 1'b1;
                if (in_full && !dev_mbx_in_ack) ovf <= 1'b1;
            end
        end
    end

    hpi_resp_ram #(
        .WORDS (MEM_WORDS),
        .WAW   (AW - 1)
    ) u_ram (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .h_we    (ram_we),
        .h_re    (ram_re),
        .h_addr  (ptr[AW-1:1]),
        .h_wdata (hpi.hpi_data_in),
        .h_rdata (ram_q),
        .l_addr  (dev_mem_addr),
        .l_rdata (dev_mem_rdata)
    );

    // DATA reads come straight from the RAM output register.
    assign hpi.hpi_data_out = (sel_q == HPI_REG_DATA) ? ram_q : reg_q;
    assign hpi.hpi_data_oe  = (prv_s == RD);
    assign hpi.hpi_int      = out_full;
    assign dev_mbx_in_valid = in_full;

endmodule

// File: tb/tb_hpi_responder.sv
// Scoreboard bench for hpi_responder: host reads push expected words,
// a negedge monitor pops and compares whenever oe is high.
module tb_hpi_responder;
    import hpi_pkg::*;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        dev_mbx_out_wr = 1'b0;
    logic [15:0] dev_mbx_out_data = '0;
    logic        dev_mbx_in_valid;
    logic [15:0] dev_mbx_in_data;
    logic        dev_mbx_in_ack = 1'b0;
    logic [7:0]  dev_mem_addr = '0;
    logic [15:0] dev_mem_rdata;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    hpi_if bus ();

    hpi_responder #(.MEM_WORDS(256)) dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .hpi              (bus),
        .dev_mbx_out_wr   (dev_mbx_out_wr),
        .dev_mbx_out_data (dev_mbx_out_data),
        .dev_mbx_in_valid (dev_mbx_in_valid),
        .dev_mbx_in_data  (dev_mbx_in_data),
        .dev_mbx_in_ack   (dev_mbx_in_ack),
        .dev_mem_addr     (dev_mem_addr),
        .dev_mem_rdata    (dev_mem_rdata)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk_clk) begin
        if (bus.hpi_data_oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h want none",
                         bus.hpi_data_out);
            end else begin
                chk("sb_read", bus.hpi_data_out, exp_q.pop_front());
            end
        end
    end

    task automatic rd_start(input logic [1:0] a, input logic [15:0] e,
                            input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
        @(posedge clk_clk); #1;
        bus.hpi_cs_n = 1'b0;
        bus.hpi_addr = a;
        bus.hpi_r_n  = 1'b0;
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic rd_stop();
        bus.hpi_cs_n = 1'b1;
        bus.hpi_r_n  = 1'b1;
    endtask

    task automatic hread(input logic [1:0] a, input logic [15:0] e);
        rd_start(a, e, 1);
        rd_stop();
    endtask

    task automatic hwrite(input logic [1:0] a, input logic [15:0] d,
                          input int n);
        @(posedge clk_clk); #1;
        bus.hpi_cs_n    = 1'b0;
        bus.hpi_addr    = a;
        bus.hpi_w_n     = 1'b0;
        bus.hpi_data_in = d;
        repeat (n) @(posedge clk_clk);
        #1;
        bus.hpi_cs_n = 1'b1;
        bus.hpi_w_n  = 1'b1;
    endtask

    task automatic dev_rd(input string nm, input logic [7:0] a,
                          input logic [15:0] e);
        @(posedge clk_clk); #1;
        dev_mem_addr = a;
        @(posedge clk_clk); #1;
        chk(nm, dev_mem_rdata, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.hpi_cs_n    = 1'b1;
        bus.hpi_addr    = 2'd0;
        bus.hpi_r_n     = 1'b1;
        bus.hpi_w_n     = 1'b1;
        bus.hpi_data_in = '0;
        #22;
        chk("rst_data_out", bus.hpi_data_out, 16'h0000);
        chk("rst_oe", {15'b0, bus.hpi_data_oe}, 16'h0);
        chk("rst_int", {15'b0, bus.hpi_int}, 16'h0);
        chk("rst_in_valid", {15'b0, dev_mbx_in_valid}, 16'h0);
        chk("rst_in_data", dev_mbx_in_data, 16'h0000);
        chk("rst_mem_rdata", dev_mem_rdata, 16'h0000);
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;

        hread(HPI_REG_STATUS, 16'h0000);

        hwrite(HPI_REG_ADDR, 16'h0010, 1);
        hwrite(HPI_REG_DATA, 16'h1234, 1);
        hwrite(HPI_REG_DATA, 16'hABCD, 1);
        hwrite(HPI_REG_ADDR, 16'h0010, 1);
        hread(HPI_REG_DATA, 16'h1234);
        hread(HPI_REG_DATA, 16'hABCD);
        hread(HPI_REG_ADDR, 16'h0014);
        dev_rd("dev_word8", 8'd8, 16'h1234);
        dev_rd("dev_word9", 8'd9, 16'hABCD);

        hwrite(HPI_REG_ADDR, 16'h01FE, 1);
        hwrite(HPI_REG_DATA, 16'h5555, 1);
        hread(HPI_REG_ADDR, 16'h0000);
        dev_rd("dev_word255", 8'd255, 16'h5555);
        hwrite(HPI_REG_ADDR, 16'h0002, 1);
        hwrite(HPI_REG_DATA, 16'h0BAD, 1);
        hwrite(HPI_REG_ADDR, 16'h0000, 1);
        hwrite(HPI_REG_DATA, 16'h7777, 10);
        hread(HPI_REG_ADDR, 16'h0002);
        dev_rd("hold_word0", 8'd0, 16'h7777);
        dev_rd("hold_word1", 8'd1, 16'h0BAD);

        @(posedge clk_clk); #1;
        dev_mbx_out_wr   = 1'b1;
        dev_mbx_out_data = 16'h00C3;
        @(posedge clk_clk); #1;
        dev_mbx_out_wr = 1'b0;
        chk("int_set", {15'b0, bus.hpi_int}, 16'h1);
        hread(HPI_REG_STATUS, 16'h0001);
        rd_start(HPI_REG_MBX, 16'h00C3, 3);
        chk("int_held", {15'b0, bus.hpi_int}, 16'h1);
        rd_stop();
        chk("int_pre_rel", {15'b0, bus.hpi_int}, 16'h1);
        @(posedge clk_clk); #1;
        chk("int_cleared", {15'b0, bus.hpi_int}, 16'h0);

        hwrite(HPI_REG_MBX, 16'h5A5A, 1);
        hwrite(HPI_REG_MBX, 16'h1111, 1);
        chk("in_data", dev_mbx_in_data, 16'h1111);
        chk("in_valid", {15'b0, dev_mbx_in_valid}, 16'h1);
        hread(HPI_REG_STATUS, 16'h8100);
        hread(HPI_REG_STATUS, 16'h0100);
        @(posedge clk_clk); #1;
        bus.hpi_cs_n    = 1'b0;
        bus.hpi_addr    = HPI_REG_MBX;
        bus.hpi_w_n     = 1'b0;
        bus.hpi_data_in = 16'h2222;
        dev_mbx_in_ack  = 1'b1;
        @(posedge clk_clk); #1;
        bus.hpi_cs_n   = 1'b1;
        bus.hpi_w_n    = 1'b1;
        dev_mbx_in_ack = 1'b0;
        chk("ack_wr_valid", {15'b0, dev_mbx_in_valid}, 16'h1);
        chk("ack_wr_data", dev_mbx_in_data, 16'h2222);
        hread(HPI_REG_STATUS, 16'h0100);
        @(posedge clk_clk); #1;
        dev_mbx_in_ack = 1'b1;
        @(posedge clk_clk); #1;
        dev_mbx_in_ack = 1'b0;
        chk("ack_valid", {15'b0, dev_mbx_in_valid}, 16'h0);

        hwrite(HPI_REG_ADDR, 16'h0020, 1);
        hwrite(HPI_REG_DATA, 16'h0F0F, 1);
        hwrite(HPI_REG_ADDR, 16'h0020, 1);
        @(posedge clk_clk); #1;
        bus.hpi_cs_n    = 1'b0;
        bus.hpi_addr    = HPI_REG_DATA;
        bus.hpi_r_n     = 1'b0;
        bus.hpi_w_n     = 1'b0;
        bus.hpi_data_in = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_clk); #1;
            chk("illegal_oe", {15'b0, bus.hpi_data_oe}, 16'h0);
        end
        bus.hpi_cs_n = 1'b1;
        bus.hpi_r_n  = 1'b1;
        bus.hpi_w_n  = 1'b1;
        hread(HPI_REG_ADDR, 16'h0020);
        dev_rd("illegal_word16", 8'd16, 16'h0F0F);

        hwrite(HPI_REG_ADDR, 16'h0040, 1);
        hwrite(HPI_REG_DATA, 16'h1111, 1);
        hwrite(HPI_REG_MBX, 16'h3333, 1);
        @(posedge clk_clk); #1;
        dev_mbx_out_wr   = 1'b1;
        dev_mbx_out_data = 16'h0044;
        @(posedge clk_clk); #1;
        dev_mbx_out_wr = 1'b0;
        chk("pre_rst_int", {15'b0, bus.hpi_int}, 16'h1);
        bus.hpi_cs_n    = 1'b0;
        bus.hpi_addr    = HPI_REG_DATA;
        bus.hpi_w_n     = 1'b0;
        bus.hpi_data_in = 16'h2222;
        @(posedge clk_clk); #1;
        #2;
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_int", {15'b0, bus.hpi_int}, 16'h0);
        chk("mid_rst_valid", {15'b0, dev_mbx_in_valid}, 16'h0);
        chk("mid_rst_in_data", dev_mbx_in_data, 16'h0000);
        bus.hpi_cs_n = 1'b1;
        bus.hpi_w_n  = 1'b1;
        #2;
        reset_reset_n = 1'b1;
        hread(HPI_REG_ADDR, 16'h0000);
        hread(HPI_REG_STATUS, 16'h0000);

        repeat (3) @(posedge clk_clk);
        #1;
        chk("sb_drain", 16'(exp_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
- HPI responder: the device end of the 4-register host-port interface that the Nios drives through its otg_hpi_* PIO ports (chip select, 2-bit address, 16-bit data in/out, read strobe, write strobe).
- Contains an addressable 16-bit word memory with auto-incrementing pointer, a bidirectional mailbox and a status register.
- Used as an on-FPGA stand-in for the USB controller, for system simulation and loopback bring-up of the HPI driver, and as a mailbox channel to local logic.

Parameters:
- MEM_WORDS, 256, number of 16-bit memory words (power of 2, 16..4096).
- AW, $clog2(MEM_WORDS)+1, width of the HPI byte address pointer.

Ports:
- clk_clk  in  1  system clock; all HPI inputs are synchronous to it.
- reset_reset_n  in  1  asynchronous active-low reset.
- hpi_cs_n  in  1  chip select, active low.
- hpi_addr  in  2  register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
- hpi_r_n  in  1  read strobe, active low.
- hpi_w_n  in  1  write strobe, active low.
- hpi_data_in  in  16  host write data (driven by the initiator's data_out).
- hpi_data_out  out  16  read data returned to the host (feeds the initiator's data_in).
- hpi_data_oe  out  1  high while a legal read is in progress.
- hpi_int  out  1  high while the outbound mailbox is full.
- dev_mbx_out_wr  in  1  local pulse: load dev_mbx_out_data into the outbound mailbox.
- dev_mbx_out_data  in  16  outbound mailbox data.
- dev_mbx_in_valid  out  1  inbound mailbox full.
- dev_mbx_in_data  out  16  inbound mailbox contents.
- dev_mbx_in_ack  in  1  local pulse: consume the inbound mailbox.
- dev_mem_addr  in  AW-1  local word read address.
- dev_mem_rdata  out  16  memory word at dev_mem_addr, 1-cycle latency.

Behaviour:
- Reset (async, reset_reset_n low) clears:
  - hpi_data_out, hpi_data_oe, hpi_int, dev_mbx_in_valid, dev_mbx_in_data and dev_mem_rdata to 0.
  - The address pointer, both mailboxes, both full flags and the overflow flag to 0.
  - The strobe edge-detect registers to "deasserted".
- Memory contents are not reset.
- Strobe qualification:
  - rd = !cs_n & !r_n & w_n; wr = !cs_n & !w_n & r_n.
  - r_n and w_n both low counts as neither: no state change and oe stays 0.
- Write commit: on the first cycle wr is true (rising edge of wr), using hpi_data_in sampled that cycle. Holding wr causes no further commits.
  - DATA: mem[ptr[AW-1:1]] <= data, then ptr += 2.
  - MAILBOX: mbx_in <= data and mbx_in_full <= 1. If it was already full and not being acked that cycle, overflow <= 1.
  - ADDRESS: ptr <= data[AW-1:0]; bit 0 is forced to 0.
  - STATUS: write is ignored.
- Read data path:
  - While rd is true, hpi_data_out is registered every cycle from the selected source, so it is valid from the 2nd cycle of rd onward.
  - Sources: DATA = mem[ptr] (synchronous RAM read); MAILBOX = mbx_out; ADDRESS = zero-extended ptr; STATUS = {overflow, 6'b0, mbx_in_full, 7'b0, mbx_out_full}.
  - hpi_data_oe = registered rd.
  - When rd is false, hpi_data_out holds its last value and oe = 0.
- Read side effects fire on the falling edge of rd (strobe release), never while the strobe is held:
  - DATA: ptr += 2.
  - MAILBOX: mbx_out_full <= 0.
  - STATUS: overflow <= 0.
- Pointer arithmetic: modulo 2^AW. A DATA access at ptr = 2*MEM_WORDS-2 wraps ptr to 0.
- Outbound mailbox:
  - dev_mbx_out_wr loads mbx_out and sets mbx_out_full.
  - If it coincides with a host MAILBOX read-release, the device write wins: full stays 1 and the new data is kept.
  - hpi_int = mbx_out_full, registered.
- Inbound mailbox:
  - dev_mbx_in_ack clears mbx_in_full.
  - If the ack coincides with a host MAILBOX write commit, the write wins: full = 1, no overflow.
  - dev_mbx_in_valid = mbx_in_full; dev_mbx_in_data = mbx_in.
- Local memory port: read-only. A local read and a host access in the same cycle both complete; a host write to the same word returns the old data that cycle.
- Reset asserted mid-burst: all of the above return to reset values immediately; the host must rewrite ADDRESS.

Decomposition:
- Package hpi_pkg holds:
  - Register address constants HPI_REG_DATA/MBX/ADDR/STATUS.
  - Status bit indices STS_MBX_OUT=0, STS_MBX_IN=8, STS_OVF=15.
  - Strobe-decode enum {IDLE, RD, WR, ILLEGAL}.
- One sub-module, hpi_resp_ram: simple dual-port synchronous RAM, one write/read port for the host and one read port for local logic.

Test Plan:
- Reset with cs_n=1 -> all outputs 0; first STATUS read returns 0x0000 with oe=1 from the 2nd cycle.
- Write ADDRESS=0x0010, DATA=0x1234, DATA=0xABCD, ADDRESS=0x0010; read DATA twice -> 0x1234 then 0xABCD; then read ADDRESS -> 0x0014; dev_mem_addr=8 -> 0x1234.
- MEM_WORDS=256, ADDRESS=0x01FE, write DATA=0x5555 -> word 255=0x5555 and ADDRESS reads 0x0000; hold w_n low 10 cycles on DATA -> exactly one commit.
- dev_mbx_out_wr with 0x00C3 -> hpi_int=1 and STATUS=0x0001; host MAILBOX read -> 0x00C3, with hpi_int still 1 until r_n rises, then 0.
- Host writes MAILBOX 0x5A5A then 0x1111 without ack -> dev_mbx_in_data=0x1111 and STATUS=0x8100, next STATUS read=0x0100; ack in the same cycle as a write commit -> valid=1, no overflow.
- r_n=w_n=0 with cs_n=0 on DATA -> no memory write, ptr unchanged, oe=0; reset pulse mid DATA burst -> ptr=0, flags cleared, hpi_int=0.
